gb_cpu_fetch: RTL
=================

GB_CPU_FETCH -- requirements
Module: gb_cpu_fetch

Interface
REQ-001 SHALL have these ports, one clock domain; reset is synchronous and active-high:
clk  in  1  sole clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
fetch_req  in  1  sequencer request for next instruction byte(s)
imm_req  in  1  sequencer request for one immediate byte at PC
pc_load  in  1  load PC from pc_load_value (jump/call/ret/rst)
pc_load_value  in  16  new PC value
mem_rdata  in  8  memory read data, valid when mem_ready=1
mem_ready  in  1  memory accepts/completes read this cycle
mem_rd  out  1  read request, held until mem_ready
mem_addr  out  16  read address, stable while mem_rd=1
pc  out  16  current program counter
opcode  out  8  decoded-side opcode, feeds decoder opcode input
cb_prefix  out  1  opcode was 0xCB-prefixed, feeds decoder cb_prefix input
opcode_valid  out  1  one-cycle pulse, opcode/cb_prefix newly updated
imm_data  out  8  last fetched immediate byte
imm_valid  out  1  one-cycle pulse, imm_data newly updated
busy  out  1  state != IDLE

Function
REQ-002 SHALL implement FSM states IDLE, FETCH_OP, FETCH_CB, FETCH_IMM.
REQ-003 IDLE: imm_req=1 -> FETCH_IMM; else fetch_req=1 -> FETCH_OP; else stay; imm_req wins if both asserted.
REQ-004 fetch_req/imm_req SHALL be ignored when busy=1.
REQ-005 pc_load SHALL take effect only in IDLE and is ignored otherwise; if pc_load and a request coincide, the fetch SHALL use pc_load_value as its address.
REQ-006 In FETCH_*: mem_rd=1, mem_addr=pc; the byte is accepted in the cycle mem_ready=1; outside FETCH_* mem_rd=0 and mem_addr holds pc.
REQ-007 On each accepted byte, pc SHALL increment by 1 modulo 2^16 (0xFFFF -> 0x0000).
REQ-008 FETCH_OP accept, mem_rdata=0xCB -> FETCH_CB, no opcode_valid pulse.
REQ-009 FETCH_OP accept, mem_rdata!=0xCB -> opcode<=mem_rdata, cb_prefix<=0, opcode_valid=1 next cycle, -> IDLE.
REQ-010 FETCH_CB accept -> opcode<=mem_rdata (0xCB included, no further prefix), cb_prefix<=1, opcode_valid=1 next cycle, -> IDLE.
REQ-011 FETCH_IMM accept -> imm_data<=mem_rdata, imm_valid=1 next cycle, -> IDLE; opcode/cb_prefix unchanged.
REQ-012 Latency: request at cycle N -> mem_rd=1 at N+1; with mem_ready=1 every cycle, opcode_valid/imm_valid at N+2 (unprefixed/immediate), N+3 (CB-prefixed).
REQ-013 mem_ready=0 SHALL stall the state with mem_addr, pc and mem_rd held; no limit on wait cycles.
REQ-014 opcode, cb_prefix, imm_data SHALL hold until next update; valid pulses last exactly one cycle.
REQ-015 All outputs SHALL be registered or decoded from state/pc only; no combinational path from mem_rdata to outputs.

Reset
REQ-016 On reset=1 at a clock edge: state=IDLE, pc=0x0000, opcode=0x00, cb_prefix=0, imm_data=0x00, opcode_valid=0, imm_valid=0, mem_rd=0, mem_addr=0x0000, busy=0.
REQ-017 Reset mid-fetch SHALL abort it: no valid pulse, partial CB prefix discarded, mem_rd=0 the following cycle.
REQ-018 Inputs SHALL be ignored while reset=1.

Verification
REQ-019 After reset, fetch_req pulse, mem_ready=1, mem[0x0000]=0x80 -> mem_rd at N+1 addr 0x0000; opcode=0x80, cb_prefix=0, opcode_valid at N+2; pc=0x0001.
REQ-020 pc=0x0100, mem[0x0100]=0xCB, mem[0x0101]=0x37, fetch_req -> addresses 0x0100, 0x0101; opcode=0x37, cb_prefix=1, single valid at N+3; pc=0x0102.
REQ-021 pc_load=1 value 0xFFFF with fetch_req, mem[0xFFFF]=0x3C, mem_ready low 3 cycles -> mem_addr 0xFFFF held 4 cycles; opcode=0x3C valid once; pc=0x0000.
REQ-022 imm_req and fetch_req together in IDLE, mem[pc]=0x42 -> imm_data=0x42, imm_valid pulse, no opcode_valid; fetch_req during busy ignored.
REQ-023 CB byte accepted, reset asserted in FETCH_CB -> no opcode_valid, pc=0x0000, mem_rd=0 next cycle; subsequent fetch_req of 0xCB,0xCB yields opcode=0xCB, cb_prefix=1.
REQ-024 pc_load asserted while busy -> pc unaffected by pc_load_value; increments only per accepted byte.

Source files
------------

// File: rtl/gb_cpu_fetch.sv
// gb_cpu_fetch: instruction/immediate byte fetch unit for a GB-style CPU core.
// Fetches one opcode (optionally 0xCB-prefixed) or one immediate byte at PC on
// request from the sequencer, advancing PC by one per accepted memory byte.
//
// Ports:
//   clk, reset        - sole clock; synchronous active-high reset
//   fetch_req         - request the next opcode (ignored while busy)
//   imm_req           - request one immediate byte (wins over fetch_req)
//   pc_load, pc_load_value - load PC, honoured only when idle
//   mem_rdata, mem_ready   - memory read data / read completion handshake
//   mem_rd, mem_addr  - read request held until mem_ready; address is PC
//   pc                - current program counter
//   opcode, cb_prefix, opcode_valid - decoded-side opcode and one-cycle pulse
//   imm_data, imm_valid             - last immediate byte and one-cycle pulse
//   busy              - a fetch is in progress
module gb_cpu_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        imm_req,
  input  logic        pc_load,
  input  logic [15:0] pc_load_value,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  output logic [15:0] pc,
  output logic [7:0]  opcode,
  output logic        cb_prefix,
  output logic        opcode_valid,
  output logic [7:0]  imm_data,
  output logic        imm_valid,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StFetchOp, StFetchCb, StFetchImm} state_e;

  state_e      state_q;
  logic [15:0] pc_q;
  logic [7:0]  opcode_q;
  logic        cb_prefix_q;
  logic        opcode_valid_q;
  logic [7:0]  imm_data_q;
  logic        imm_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      pc_q           <= 16'h0000;
      opcode_q       <= 8'h00;
      cb_prefix_q    <= 1'b0;
      opcode_valid_q <= 1'b0;
      imm_data_q     <= 8'h00;
      imm_valid_q    <= 1'b0;
    end else begin
      // Valid flags are pulses: cleared unless set by an accept this cycle.
      opcode_valid_q <= 1'b0;
      imm_valid_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // A coincident request reads from the loaded PC since mem_addr is pc.
          if (pc_load) pc_q <= pc_load_value;
          if (imm_req) begin
            state_q <= StFetchImm;
          end else if (fetch_req) begin
            state_q <= StFetchOp;
          end
        end
        StFetchOp: begin
          if (mem_ready) begin
            pc_q <= pc_q + 16'd1;
            if (mem_rdata == 8'hCB) begin
              state_q <= StFetchCb;
            end else begin
              opcode_q       <= mem_rdata;
              cb_prefix_q    <= 1'b0;
              opcode_valid_q <= 1'b1;
              state_q        <= StIdle;
            end
          end
        end
        StFetchCb: begin
          // Second byte is always the opcode proper, even if it is 0xCB.
          if (mem_ready) begin
            pc_q           <= pc_q + 16'd1;
            opcode_q       <= mem_rdata;
            cb_prefix_q    <= 1'b1;
            opcode_valid_q <= 1'b1;
            state_q        <= StIdle;
          end
        end
        StFetchImm: begin
          if (mem_ready) begin
            pc_q        <= pc_q + 16'd1;
            imm_data_q  <= mem_rdata;
            imm_valid_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Decoded from state/pc only; nothing here depends on mem_rdata.
  assign busy         = (state_q != StIdle);
  assign mem_rd       = busy;
  assign mem_addr     = pc_q;
  assign pc           = pc_q;
  assign opcode       = opcode_q;
  assign cb_prefix    = cb_prefix_q;
  assign opcode_valid = opcode_valid_q;
  assign imm_data     = imm_data_q;
  assign imm_valid    = imm_valid_q;

endmodule
